// File: rtl/shift_add_mult_ctrl.sv
// Iterative unsigned shift-and-add multiplier: one WIDTH-bit FullAdder chain
// reused over WIDTH cycles, valid/ready handshakes on operands and product.

module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module shift_add_mult_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic [1:0]         rs_q;
  logic               rst_sync;
  logic [WIDTH-1:0]   mcand_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0]   acc_hi_d, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [WIDTH-1:0]   add_b, sum;
  logic [WIDTH:0]     carry;

  // Reset asserts asynchronously, releases two edges later on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rs_q <= 2'b00;
    else        rs_q <= {rs_q[0], 1'b1};
  end
  assign rst_sync = rs_q[1];

  assign carry[0] = 1'b0;
  assign add_b    = acc_lo_q[0] ? mcand_q : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    FullAdder u_fa (
      .a    (acc_hi_q[i]),
      .b    (add_b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Right shift of {cout, sum, acc_lo}; keeps every iteration's carry.
  assign acc_hi_d = {carry[WIDTH], sum[WIDTH-1:1]};
  assign acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !rst_sync) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= a;
            acc_hi_q   <= '0;
            acc_lo_q   <= b;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        BUSY: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = {acc_hi_q, acc_lo_q};

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Iterative unsigned shift-and-add multiplier controller. It time-shares one WIDTH-bit ripple-carry adder, built as a chain of FullAdder instances, across WIDTH iterations.
- Operands enter through a valid/ready handshake.
- The 2*WIDTH-bit product leaves through a second valid/ready handshake.
- It is the low-area sequential counterpart to the parallel Wallace multiplier and shares its operand/product conventions.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk        input   1          rising-edge clock
rst_n      input   1          asynchronous active-low reset
in_valid   input   1          operand pair valid
in_ready   output  1          controller can accept operands
a          input   WIDTH      multiplicand, unsigned
b          input   WIDTH      multiplier, unsigned
out_valid  output  1          product valid
out_ready  input   1          downstream accepts product
product    output  2*WIDTH    a*b, unsigned
busy       output  1          high in BUSY state

Behaviour:
- Clocking and reset: one clock domain (clk). rst_n is asynchronous, active-low; it asserts immediately and releases synchronously through a 2-flop deassertion inside the block.
- Reset values:
  - state=IDLE
  - in_ready=1 (after reset release)
  - out_valid=0, busy=0
  - product=0
  - all internal registers 0
- State machine (IDLE, BUSY, DONE):
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge:
    - mcand<=a, acc_hi<=0, acc_lo<=b, cnt<=0
    - go to BUSY.
  - BUSY: in_ready=0, busy=1. Each edge performs one iteration:
    - sum={cout,s} = acc_lo[0] ? acc_hi+mcand : acc_hi+0, computed by the shared ripple adder with cin=0.
    - {acc_hi,acc_lo} <= {cout,s,acc_lo[WIDTH-1:1]}, a logical right shift of the (2*WIDTH+1)-bit {cout,s,acc_lo}.
    - cnt<=cnt+1.
    - When cnt==WIDTH-1 at the edge, go to DONE on that same edge.
  - DONE: out_valid=1, product={acc_hi,acc_lo}, held stable while out_ready=0. When out_valid&&out_ready at an edge, go to IDLE and drop out_valid.
- Latency and throughput:
  - Operands accepted at edge k → out_valid first high after edge k+WIDTH.
  - The earliest next accept is the edge after the product handshake.
  - One transaction in flight at a time; no skid buffer.
- Adder: exactly one WIDTH-bit FullAdder chain. The adder's B input is muxed between mcand and 0. No other adders are inferred in the datapath. The cnt increment is allowed as a separate small counter.
- Boundary conditions:
  - in_valid during BUSY/DONE: ignored. in_ready=0, a/b not sampled, no state change.
  - Operand zero (a=0 or b=0): fixed latency is kept; result is 0.
  - Max operands: cout of every iteration is retained via the shift. (2^W-1)^2 must fit in 2*WIDTH bits without loss.
  - out_ready high while not in DONE: no effect.
  - out_ready held high continuously: DONE lasts exactly one cycle.
  - a/b changing after acceptance: no effect on the in-flight result.
- Reset mid-operation: asserting rst_n=0 in any state immediately clears out_valid/busy/product and returns to IDLE. The in-flight transaction is discarded and no product is emitted.
- Handshake rules:
  - out_valid never deasserts without out_ready.
  - product is constant while out_valid=1.
  - in_ready and out_valid are never both high.

Test Plan:
- WIDTH=8: a=13, b=11, out_ready=1 → out_valid high exactly 8 cycles after accept edge; product=143; busy high for 8 cycles; in_ready returns after product handshake.
- WIDTH=8: a=255, b=255 → product=65025 (0xFE01), verifying carry retention on every iteration. Also a=0,b=200 and a=200,b=0 → product=0 after 8 cycles.
- Backpressure: a=7, b=9, out_ready=0 for 20 cycles after out_valid → product=63 and out_valid held stable throughout; release out_ready → IDLE next edge, in_ready=1.
- Ignored input: accept a=3, b=5, then drive in_valid=1 with a=100, b=100 during BUSY and DONE → product=15, in_ready=0 the whole time, second pair never accepted.
- Reset mid-operation: accept a=200, b=150, assert rst_n=0 after 4 cycles → out_valid/busy/product=0 immediately; after release, a=6, b=7 → product=42 with full 8-cycle latency.
- Back-to-back, then randomized: 1000 random pairs with random in_valid/out_ready gaps, WIDTH=8 and WIDTH=16 → every product equals a*b; handshake invariants hold every cycle.
